snd_event_seq: RTL and testbench

Parametrised sound-event sequencer for the game audio path, sitting between game-logic event strobes and the I2S tone generator.
- Detects rising edges on N_EVT event lines and queues them as one-shot requests.
- Arbitrates by fixed priority and plays one tone at a time with per-channel period, duration and sweep.
- Inserts a reset gap between tones.
- Generalises the two-sweep, three-event sound logic to N channels with configurable timing.

---
 rtl/snd_pkg.sv | 24 ++
 rtl/snd_edge_queue.sv | 43 ++++
 rtl/snd_event_seq.sv | 169 ++++++++++++++++
 tb/tb_snd_event_seq.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared definitions for the sound-event sequencer: FSM encoding, sweep modes
// and a lowest-set-bit helper used for fixed-priority channel selection.
package snd_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [1:0] SWP_NONE = 2'b00;
  localparam logic [1:0] SWP_UP   = 2'b01;
  localparam logic [1:0] SWP_DOWN = 2'b10;

  // Lowest set index wins; callers zero-extend up to 16 channels.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/snd_edge_queue.sv
// Rising-edge detector and one-shot pending queue for the event lines.
// A rise on an already-pending channel that is not being cleared reports a drop.
module snd_edge_queue
  import snd_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] evt_in,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pending,
  output logic [N-1:0] dropped
);

  logic [N-1:0] evt_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] drop_q, drop_d;
  logic [N-1:0] rise;

  always_comb begin
    rise   = evt_in & ~evt_q;
    // A set in the same cycle as a clear wins, and is not a drop.
    pend_d = (pend_q & ~clr) | rise;
    drop_d = rise & pend_q & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      evt_q  <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      evt_q  <= evt_in;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  assign pending = pend_q;
  assign dropped = drop_q;

endmodule

// File: rtl/snd_event_seq.sv
// Fixed-priority sound-event sequencer: IDLE -> LOAD -> PLAY -> GAP.
// Optional macro SND_PREEMPT_EN lets a higher-priority pending event abort PLAY.
module snd_event_seq
  import snd_pkg::*;
#(
  parameter int N_EVT     = 4,
  parameter int PER_W     = 16,
  parameter int DUR_W     = 24,
  parameter int GAP_CYC   = 4,
  parameter int SWEEP_DIV = 8,
  parameter int PER_MIN   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_EVT-1:0]           evt_in,
  input  logic [N_EVT*PER_W-1:0]     cfg_period,
  input  logic [N_EVT*DUR_W-1:0]     cfg_dur,
  input  logic [N_EVT*2-1:0]         cfg_sweep,
  input  logic [PER_W-1:0]           sweep_step,
  output logic                       tone_en,
  output logic [PER_W-1:0]           tone_period,
  output logic                       tone_rst,
  output logic [$clog2(N_EVT)-1:0]   active_ch,
  output logic                       busy,
  output logic                       done,
  output logic [N_EVT-1:0]           dropped
);

  localparam int CH_W  = $clog2(N_EVT);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int DIV_W = $clog2(SWEEP_DIV + 1);
  localparam logic [PER_W-1:0] PMIN = PER_W'(PER_MIN);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [1:0]        swp_q, swp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [N_EVT-1:0]  pending;
  logic [N_EVT-1:0]  clr;
  logic [3:0]        sel_idx;
  logic              preempt;
  logic              last_cyc;
  logic [DUR_W-1:0]  cfg_dur_sel;

  function automatic logic [PER_W-1:0] sat_up(input logic [PER_W-1:0] p,
                                              input logic [PER_W-1:0] s);
    logic [PER_W:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return sum[PER_W] ? '1 : sum[PER_W-1:0];
  endfunction

  // A period already under the floor is left alone rather than pulled up.
  function automatic logic [PER_W-1:0] sat_down(input logic [PER_W-1:0] p,
                                                input logic [PER_W-1:0] s);
    logic [PER_W:0] diff;
    if (p < PMIN) return p;
    diff = {1'b0, p} - {1'b0, s};
    if (diff[PER_W] || (diff[PER_W-1:0] < PMIN)) return PMIN;
    return diff[PER_W-1:0];
  endfunction

  snd_edge_queue #(.N(N_EVT)) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .evt_in  (evt_in),
    .clr     (clr),
    .pending (pending),
    .dropped (dropped)
  );

  assign sel_idx     = lowest_set(16'(pending));
  assign cfg_dur_sel = cfg_dur[ch_q*DUR_W +: DUR_W];

`ifdef SND_PREEMPT_EN
  logic [N_EVT-1:0] hi_pri;
  always_comb begin
    hi_pri = '0;
    for (int i = 0; i < N_EVT; i++) begin
      hi_pri[i] = (CH_W'(i) < ch_q);
    end
  end
  assign preempt = |(pending & hi_pri);
`else
  assign preempt = 1'b0;
`endif

  assign last_cyc = (dur_q == DUR_W'(1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    per_d   = per_q;
    dur_d   = dur_q;
    swp_d   = swp_q;
    div_d   = div_q;
    gap_d   = gap_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          ch_d    = sel_idx[CH_W-1:0];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        clr     = N_EVT'(1) << ch_q;
        per_d   = cfg_period[ch_q*PER_W +: PER_W];
        dur_d   = (cfg_dur_sel == '0) ? DUR_W'(1) : cfg_dur_sel;
        swp_d   = cfg_sweep[ch_q*2 +: 2];
        div_d   = '0;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (preempt || last_cyc) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CYC - 1);
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
        if (div_q == DIV_W'(SWEEP_DIV - 1)) begin
          div_d = '0;
          case (swp_q)
            SWP_UP:   per_d = sat_up(per_q, sweep_step);
            SWP_DOWN: per_d = sat_down(per_q, sweep_step);
            default:  per_d = per_q;
          endcase
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      per_q   <= '0;
      dur_q   <= '0;
      swp_q   <= SWP_NONE;
      div_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      per_q   <= per_d;
      dur_q   <= dur_d;
      swp_q   <= swp_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
    end
  end

  assign tone_en     = (state_q == ST_PLAY);
  assign tone_rst    = (state_q == ST_GAP);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_PLAY) && last_cyc && !preempt;
  assign tone_period = per_q;
  assign active_ch   = ch_q;

endmodule

// File: tb/tb_snd_event_seq.sv
// Scenario bench for snd_event_seq: expected plays are queued at stimulus time
// and compared against plays recorded from the DUT outputs.
module tb_snd_event_seq;

  localparam int N_EVT = 4;
  localparam int PER_W = 16;
  localparam int DUR_W = 24;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] per;
    logic [15:0] len;
    logic [3:0]  dn;
  } rec_t;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N_EVT-1:0]       evt_in;
  logic [N_EVT*PER_W-1:0] cfg_period;
  logic [N_EVT*DUR_W-1:0] cfg_dur;
  logic [N_EVT*2-1:0]     cfg_sweep;
  logic [PER_W-1:0]       sweep_step;
  logic                   tone_en, tone_rst, busy, done;
  logic [PER_W-1:0]       tone_period;
  logic [1:0]             active_ch;
  logic [N_EVT-1:0]       dropped;

  logic [PER_W-1:0] per_c [N_EVT];
  logic [DUR_W-1:0] dur_c [N_EVT];
  logic [1:0]       sw_c  [N_EVT];

  for (genvar g = 0; g < N_EVT; g++) begin : g_cfg
    assign cfg_period[g*PER_W +: PER_W] = per_c[g];
    assign cfg_dur[g*DUR_W +: DUR_W]    = dur_c[g];
    assign cfg_sweep[g*2 +: 2]          = sw_c[g];
  end

  snd_event_seq #(
    .N_EVT(N_EVT), .PER_W(PER_W), .DUR_W(DUR_W),
    .GAP_CYC(4), .SWEEP_DIV(8), .PER_MIN(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .evt_in(evt_in),
    .cfg_period(cfg_period), .cfg_dur(cfg_dur), .cfg_sweep(cfg_sweep),
    .sweep_step(sweep_step), .tone_en(tone_en), .tone_period(tone_period),
    .tone_rst(tone_rst), .active_ch(active_ch), .busy(busy), .done(done),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  int   gap_q[$];

  rec_t cur;
  bit   in_play = 0;
  int   gap_run = 0;

  always @(negedge clk) begin
    if (tone_en) begin
      if (!in_play) begin
        cur.ch  = active_ch;
        cur.per = tone_period;
        cur.len = '0;
        cur.dn  = '0;
        in_play = 1;
      end
      cur.len = cur.len + 16'd1;
      if (done) cur.dn = cur.dn + 4'd1;
    end else if (in_play) begin
      obs_q.push_back(cur);
      in_play = 0;
    end
    if (tone_rst) gap_run++;
    else if (gap_run != 0) begin
      gap_q.push_back(gap_run);
      gap_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch);
    evt_in[ch] = 1'b1;
    @(negedge clk);
    evt_in[ch] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) quiet = 0;
      else      quiet++;
      if (quiet >= 4) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_tone(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tone_en) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic rec_t mk(input int ch, input int per, input int len, input int dn);
    rec_t r;
    r.ch = 2'(ch); r.per = 16'(per); r.len = 16'(len); r.dn = 4'(dn);
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_checks++;
    if ({tone_en, tone_rst, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: en/rst/busy/done=%b, expected 0000", {tone_en, tone_rst, busy, done});
    end
    n_checks++;
    if (tone_period !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_period: got %0d, expected 0", tone_period);
    end
    n_checks++;
    if (active_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ch: got %0d, expected 0", active_ch);
    end
    n_checks++;
    if (dropped !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dropped: got %b, expected 0000", dropped);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    bit ok;
    rec_t e, o;
    evt_in[1] = 1'b1;
    exp_q.push_back(mk(1, 100, 10, 1));
    tick(2);
    n_checks++;
    if ({busy, tone_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_load: busy/tone_en=%b, expected 10", {busy, tone_en});
    end
    tick(1);
    n_checks++;
    if (tone_en !== 1'b1 || tone_period !== 16'd100) begin
      n_fail++;
      $display("FAIL basic_start: tone_en=%b period=%0d, expected 1 and 100", tone_en, tone_period);
    end
    tick(47);
    evt_in[1] = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_idle: busy still %b, expected 0", busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_play: got ch=%0d per=%0d len=%0d done=%0d, expected ch=%0d per=%0d len=%0d done=%0d",
                 o.ch, o.per, o.len, o.dn, e.ch, e.per, e.len, e.dn);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_replay: %0d extra plays, expected 0", obs_q.size());
    end
    n_checks++;
    if (gap_q.size() != 1 || gap_q[0] != 4) begin
      n_fail++;
      $display("FAIL basic_gap: %0d gaps first=%0d, expected one gap of 4",
               gap_q.size(), (gap_q.size() != 0) ? gap_q[0] : -1);
    end
    obs_q.delete();
    gap_q.delete();
  endtask

  task automatic test_priority();
    bit ok;
    rec_t e, o;
    evt_in[2] = 1'b1;
    evt_in[0] = 1'b1;
    exp_q.push_back(mk(0, 50, 20, 1));
    exp_q.push_back(mk(2, 70, 5, 1));
    tick(1);
    evt_in = '0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL prio_idle: busy still %b, expected 0", busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL prio_play: got ch=%0d per=%0d len=%0d done=%0d, expected ch=%0d per=%0d len=%0d done=%0d",
                 o.ch, o.per, o.len, o.dn, e.ch, e.per, e.len, e.dn);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_extra: %0d extra plays, expected 0", obs_q.size());
    end
    obs_q.delete();
    gap_q.delete();
  endtask

  task automatic test_sweep();
    bit ok;
    int dn_tab [5];
    int up_tab [3];
    dn_tab = '{40, 30, 20, 16, 16};
    up_tab = '{16'hFFF8, 16'hFFFF, 16'hFFFF};
    per_c[1] = 16'd40; dur_c[1] = 24'd40; sw_c[1] = 2'b10;
    sweep_step = 16'd10;
    pulse(1);
    wait_tone(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sweep_dn_start: tone_en=%b, expected 1", tone_en);
    end
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (tone_period !== 16'(dn_tab[i/8])) begin
        n_fail++;
        $display("FAIL sweep_dn: cycle %0d period %0d, expected %0d", i, tone_period, dn_tab[i/8]);
      end
      @(negedge clk);
    end
    wait_idle(ok);
    per_c[3] = 16'hFFF8; dur_c[3] = 24'd20; sw_c[3] = 2'b01;
    sweep_step = 16'd16;
    pulse(3);
    wait_tone(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sweep_up_start: tone_en=%b, expected 1", tone_en);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (tone_period !== 16'(up_tab[i/8])) begin
        n_fail++;
        $display("FAIL sweep_up: cycle %0d period %h, expected %h", i, tone_period, up_tab[i/8]);
      end
      @(negedge clk);
    end
    wait_idle(ok);
    per_c[1] = 16'd100; dur_c[1] = 24'd10; sw_c[1] = 2'b00;
    per_c[3] = 16'd90;  dur_c[3] = 24'd8;  sw_c[3] = 2'b00;
    obs_q.delete();
    gap_q.delete();
  endtask

  task automatic test_drop_replay();
    bit ok;
    rec_t e, o;
    exp_q.push_back(mk(0, 50, 20, 1));
    exp_q.push_back(mk(3, 90, 8, 1));
    pulse(0);
    wait_tone(ok);
    evt_in[3] = 1'b1;
    tick(1);
    n_checks++;
    if (dropped !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_first: dropped=%b, expected 0000", dropped);
    end
    evt_in[3] = 1'b0;
    tick(1);
    evt_in[3] = 1'b1;
    tick(1);
    n_checks++;
    if (dropped !== 4'b1000) begin
      n_fail++;
      $display("FAIL drop_second: dropped=%b, expected 1000", dropped);
    end
    evt_in[3] = 1'b0;
    wait_idle(ok);
    exp_q.push_back(mk(0, 50, 20, 1));
    exp_q.push_back(mk(0, 50, 20, 1));
    pulse(0);
    wait_tone(ok);
    tick(3);
    pulse(0);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drop_idle: busy still %b, expected 0", busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL drop_play: got ch=%0d per=%0d len=%0d done=%0d, expected ch=%0d per=%0d len=%0d done=%0d",
                 o.ch, o.per, o.len, o.dn, e.ch, e.per, e.len, e.dn);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_extra: %0d extra plays, expected 0", obs_q.size());
    end
    obs_q.delete();
    gap_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int busy_seen = 0;
    dur_c[2] = 24'd100;
    pulse(2);
    wait_tone(ok);
    tick(5);
    pulse(3);
    tick(3);
    reset_n = 1'b0;
    tick(1);
    n_checks++;
    if ({tone_en, tone_rst, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: en/rst/busy/done=%b, expected 0000", {tone_en, tone_rst, busy, done});
    end
    n_checks++;
    if (tone_period !== 16'd0 || active_ch !== 2'd0 || dropped !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_data: period=%0d ch=%0d dropped=%b, expected 0 0 0000", tone_period, active_ch, dropped);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_pending: busy for %0d cycles after reset, expected 0", busy_seen);
    end
    obs_q.delete();
    gap_q.delete();
  endtask

  task automatic test_preempt();
    bit ok;
    rec_t e, o;
`ifdef SND_PREEMPT_EN
    exp_q.push_back(mk(2, 70, 22, 0));
`else
    exp_q.push_back(mk(2, 70, 100, 1));
`endif
    exp_q.push_back(mk(0, 50, 20, 1));
    pulse(2);
    wait_tone(ok);
    tick(20);
    pulse(0);
`ifdef SND_PREEMPT_EN
    tick(1);
    n_checks++;
    if ({tone_en, tone_rst} !== 2'b01) begin
      n_fail++;
      $display("FAIL preempt_abort: tone_en/tone_rst=%b, expected 01", {tone_en, tone_rst});
    end
`endif
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL preempt_idle: busy still %b, expected 0", busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL preempt_play: got ch=%0d per=%0d len=%0d done=%0d, expected ch=%0d per=%0d len=%0d done=%0d",
                 o.ch, o.per, o.len, o.dn, e.ch, e.per, e.len, e.dn);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL preempt_extra: %0d extra plays, expected 0", obs_q.size());
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    evt_in     = '0;
    sweep_step = '0;
    per_c[0] = 16'd50;  dur_c[0] = 24'd20; sw_c[0] = 2'b00;
    per_c[1] = 16'd100; dur_c[1] = 24'd10; sw_c[1] = 2'b00;
    per_c[2] = 16'd70;  dur_c[2] = 24'd5;  sw_c[2] = 2'b00;
    per_c[3] = 16'd90;  dur_c[3] = 24'd8;  sw_c[3] = 2'b00;
    test_reset();
    test_basic();
    test_priority();
    test_sweep();
    test_drop_replay();
    test_reset_mid();
    test_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
